// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory controller.
//   ctrl_state_t : controller state (EMPTY / LOAD / RUN)
//   DEF_*        : default word width, address width and depth
//   idx_width()  : bits needed to index a memory of a given depth
package instr_mem_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } ctrl_state_t;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_W word storage with one synchronous write port and one
// synchronous read port. The read register only updates when re is high,
// so rdata holds the last word read.
//   clk   : clock
//   we    : write enable; waddr / wdata give the word and its value
//   re    : read enable; raddr selects the word, rdata is registered
module instr_mem_array
    import instr_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int IDX_W = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset so it maps onto RAM; validity is tracked
    // by per-word written flags in the controller instead.
    always_ff @(posedge clk) begin
        if (we) begin
            // NOTE: non-blocking assignment so every register sees the
            // pre-edge values of the others, independent of block order.
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: a program is streamed in through the
// load beat interface, after which single-cycle-latency fetches are served.
//   clk, rst_n                          : clock, async active-low reset
//   load_start                          : pulse, (re)starts a program load
//   load_valid / load_data / load_last  : load beat
//   load_ready                          : high while beats are accepted
//   load_done                           : one-cycle pulse after a load ends
//   fetch_req / fetch_addr / fetch_stall: fetch request and pipeline stall
//   instr / instr_valid / fetch_fault   : fetch response
//   mem_ready                           : memory holds a program (RUN)
module instr_mem_ctrl
    import instr_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_stall,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fetch_fault,
    output logic              mem_ready
);

    localparam int               IDX_W     = idx_width(DEPTH);
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    ctrl_state_t       state_q, state_d;
    logic [IDX_W-1:0]  ptr_q;
    logic [DEPTH-1:0]  written_q;
    logic              load_done_q;
    logic              instr_valid_q;
    logic              fetch_fault_q;
    // Set when the current response must read as zero (out-of-range or
    // unwritten word, or nothing fetched since reset).
    logic              resp_zero_q;
    logic [DATA_W-1:0] rdata;

    logic              beat;
    logic              exit_load;
    logic              in_range;
    logic              fetch_acc;
    logic [IDX_W-1:0]  fetch_idx;

    assign load_ready = (state_q == LOAD);
    assign mem_ready  = (state_q == RUN);

    // A load_start in the same cycle wins over the beat.
    assign beat      = load_ready && load_valid && !load_start;
    assign exit_load = beat && (load_last || (ptr_q == LAST_IDX));

    assign in_range  = ({1'b0, fetch_addr} < DEPTH_EXT);
    assign fetch_idx = fetch_addr[IDX_W-1:0];
    assign fetch_acc = mem_ready && fetch_req && !fetch_stall && !load_start;

    always_comb begin
        // NOTE: default first so every path assigns state_d; no latch.
        state_d = state_q;
        if (load_start) begin
            state_d = LOAD;
        end else if (exit_load) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            ptr_q       <= '0;
            written_q   <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_done_q <= exit_load;
            if (load_start) begin
                ptr_q     <= '0;
                written_q <= '0;
            end else if (beat) begin
                ptr_q            <= ptr_q + IDX_W'(1);
                written_q[ptr_q] <= 1'b1;
            end
        end
    end

    // Response flags. Leaving RUN (or a load_start) clears them regardless
    // of stall; a stall in RUN freezes them together with the read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            resp_zero_q   <= 1'b1;
        end else if (!mem_ready || load_start) begin
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else if (!fetch_stall) begin
            instr_valid_q <= fetch_req;
            fetch_fault_q <= fetch_req && !in_range;
            if (fetch_req) begin
                resp_zero_q <= !in_range || !written_q[fetch_idx];
            end
        end
    end

    instr_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (beat),
        .waddr (ptr_q),
        .wdata (load_data),
        .re    (fetch_acc && in_range),
        .raddr (fetch_idx),
        .rdata (rdata)
    );

    assign instr       = resp_zero_q ? '0 : rdata;
    assign instr_valid = instr_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign load_done   = load_done_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Self-checking bench for instr_mem_ctrl: directed scenarios with fixed
// expected values, then randomized traffic against a behavioural model.
module tb_instr_mem_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 16;

    logic              clk         = 1'b0;
    logic              rst_n       = 1'b1;
    logic              load_start  = 1'b0;
    logic              load_valid  = 1'b0;
    logic [DATA_W-1:0] load_data   = '0;
    logic              load_last   = 1'b0;
    logic              fetch_req   = 1'b0;
    logic [ADDR_W-1:0] fetch_addr  = '0;
    logic              fetch_stall = 1'b0;
    logic              load_ready, load_done, instr_valid, fetch_fault, mem_ready;
    logic [DATA_W-1:0] instr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_mem_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_stall (fetch_stall),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault),
        .mem_ready   (mem_ready)
    );

    // ---------------- behavioural model ----------------
    int                m_mode;            // 0 = empty, 1 = loading, 2 = running
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_wr  [DEPTH];
    int                m_ptr;
    logic [DATA_W-1:0] m_instr;
    bit                m_valid, m_fault, m_done;

    task automatic model_reset();
        m_mode  = 0;
        m_ptr   = 0;
        foreach (m_wr[i]) m_wr[i] = 1'b0;
        m_instr = '0;
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_done  = 1'b0;
    endtask

    // Applies one rising edge worth of the block's rules to the model,
    // using the inputs as they stand at the edge.
    task automatic model_edge();
        bit take_beat;
        int a;
        take_beat = (m_mode == 1) && load_valid && !load_start;
        a = int'(fetch_addr);
        m_done = 1'b0;
        if (load_start || m_mode != 2) begin
            m_valid = 1'b0;
            m_fault = 1'b0;
        end else if (!fetch_stall) begin
            if (fetch_req) begin
                m_valid = 1'b1;
                if (a >= DEPTH) begin
                    m_instr = '0;
                    m_fault = 1'b1;
                end else begin
                    m_instr = m_wr[a] ? m_mem[a] : '0;
                    m_fault = 1'b0;
                end
            end else begin
                m_valid = 1'b0;
                m_fault = 1'b0;
            end
        end
        if (load_start) begin
            m_mode = 1;
            m_ptr  = 0;
            foreach (m_wr[i]) m_wr[i] = 1'b0;
        end else if (take_beat) begin
            m_mem[m_ptr] = load_data;
            m_wr[m_ptr]  = 1'b1;
            m_ptr++;
            if (load_last || m_ptr == DEPTH) begin
                m_mode = 2;
                m_done = 1'b1;
            end
        end
    endtask

    // One clock: model follows the edge, outputs are then sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        load_start  = 1'b0;
        load_valid  = 1'b0;
        load_last   = 1'b0;
        fetch_req   = 1'b0;
        fetch_stall = 1'b0;
    endtask

    task automatic load_words(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                              input logic [DATA_W-1:0] w2);
        idle();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data = w0; tick();
        load_data = w1; tick();
        load_data = w2; load_last = 1'b1; tick();
        idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (instr !== '0)       begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_checks++; if (instr_valid !== 0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_checks++; if (fetch_fault !== 0)  begin n_fail++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
        n_checks++; if (load_ready !== 0)   begin n_fail++; $display("FAIL reset_load_ready: got %b want 0", load_ready); end
        n_checks++; if (load_done !== 0)    begin n_fail++; $display("FAIL reset_load_done: got %b want 0", load_done); end
        n_checks++; if (mem_ready !== 0)    begin n_fail++; $display("FAIL reset_mem_ready: got %b want 0", mem_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (instr_valid !== 0) begin n_fail++; $display("FAIL empty_fetch_valid: got %b want 0", instr_valid); end
            n_checks++; if (mem_ready !== 0)   begin n_fail++; $display("FAIL empty_mem_ready: got %b want 0", mem_ready); end
        end
        idle();
    endtask

    task automatic test_load_short();
        int done_cnt = 0;
        idle();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        n_checks++; if (load_ready !== 1) begin n_fail++; $display("FAIL short_ready_in_load: got %b want 1", load_ready); end
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = DATA_W'(32'h11 * (i + 1));
            load_last  = (i == 2);
            tick();
            if (load_done === 1'b1) done_cnt++;
        end
        idle();
        n_checks++; if (load_ready !== 0) begin n_fail++; $display("FAIL short_ready_after: got %b want 0", load_ready); end
        n_checks++; if (mem_ready !== 1)  begin n_fail++; $display("FAIL short_mem_ready: got %b want 1", mem_ready); end
        fetch_req  = 1'b1;
        fetch_addr = 16'd1;
        tick();
        fetch_req = 1'b0;
        if (load_done === 1'b1) done_cnt++;
        n_checks++; if (done_cnt !== 1)         begin n_fail++; $display("FAIL short_done_pulses: got %0d want 1", done_cnt); end
        n_checks++; if (instr !== 32'h22)       begin n_fail++; $display("FAIL short_fetch1_instr: got %h want 22", instr); end
        n_checks++; if (instr_valid !== 1)      begin n_fail++; $display("FAIL short_fetch1_valid: got %b want 1", instr_valid); end
        tick();
        n_checks++; if (instr_valid !== 0)      begin n_fail++; $display("FAIL short_idle_valid: got %b want 0", instr_valid); end
        n_checks++; if (instr !== 32'h22)       begin n_fail++; $display("FAIL short_idle_instr_hold: got %h want 22", instr); end
    endtask

    task automatic test_load_full();
        logic [DATA_W-1:0] words [DEPTH];
        idle();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            words[i]   = $urandom;
            load_valid = 1'b1;
            load_data  = words[i];
            tick();
            if (i == DEPTH - 2) begin
                n_checks++; if (load_ready !== 1) begin n_fail++; $display("FAIL full_ready_before_last: got %b want 1", load_ready); end
            end
        end
        idle();
        n_checks++; if (load_ready !== 0) begin n_fail++; $display("FAIL full_ready_drop: got %b want 0", load_ready); end
        n_checks++; if (load_done !== 1)  begin n_fail++; $display("FAIL full_done: got %b want 1", load_done); end
        n_checks++; if (mem_ready !== 1)  begin n_fail++; $display("FAIL full_mem_ready: got %b want 1", mem_ready); end
        // Back-to-back fetches: word 15 first, then 0..14 on consecutive cycles.
        fetch_req = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            int a;
            a = (k == 0) ? DEPTH - 1 : k - 1;
            fetch_addr = ADDR_W'(a);
            tick();
            n_checks++; if (instr !== words[a]) begin n_fail++; $display("FAIL full_fetch_%0d: got %h want %h", a, instr, words[a]); end
            n_checks++; if (instr_valid !== 1)  begin n_fail++; $display("FAIL full_fetch_valid_%0d: got %b want 1", a, instr_valid); end
        end
        idle();
        tick();
    endtask

    task automatic test_fault();
        load_words(32'h101, 32'h202, 32'h303);
        fetch_req  = 1'b1;
        fetch_addr = 16'd20;
        tick();
        n_checks++; if (instr !== '0)      begin n_fail++; $display("FAIL oor_instr: got %h want 0", instr); end
        n_checks++; if (fetch_fault !== 1) begin n_fail++; $display("FAIL oor_fault: got %b want 1", fetch_fault); end
        n_checks++; if (instr_valid !== 1) begin n_fail++; $display("FAIL oor_valid: got %b want 1", instr_valid); end
        fetch_addr = 16'd5;
        tick();
        n_checks++; if (instr !== '0)      begin n_fail++; $display("FAIL unwritten_instr: got %h want 0", instr); end
        n_checks++; if (fetch_fault !== 0) begin n_fail++; $display("FAIL unwritten_fault: got %b want 0", fetch_fault); end
        n_checks++; if (instr_valid !== 1) begin n_fail++; $display("FAIL unwritten_valid: got %b want 1", instr_valid); end
        fetch_addr = 16'd2;
        tick();
        n_checks++; if (instr !== 32'h303) begin n_fail++; $display("FAIL after_fault_instr: got %h want 303", instr); end
        idle();
    endtask

    task automatic test_stall();
        logic [ADDR_W-1:0] addrs [3];
        addrs[0] = 16'd1; addrs[1] = 16'd2; addrs[2] = 16'd20;
        fetch_req  = 1'b1;
        fetch_addr = 16'd0;
        tick();
        n_checks++; if (instr !== 32'h101) begin n_fail++; $display("FAIL stall_first_instr: got %h want 101", instr); end
        fetch_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_addr = addrs[i];
            tick();
            n_checks++; if (instr !== 32'h101)  begin n_fail++; $display("FAIL stall_hold_instr_%0d: got %h want 101", i, instr); end
            n_checks++; if (instr_valid !== 1)  begin n_fail++; $display("FAIL stall_hold_valid_%0d: got %b want 1", i, instr_valid); end
            n_checks++; if (fetch_fault !== 0)  begin n_fail++; $display("FAIL stall_hold_fault_%0d: got %b want 0", i, fetch_fault); end
        end
        idle();
        tick();
        n_checks++; if (instr_valid !== 0)  begin n_fail++; $display("FAIL stall_release_valid: got %b want 0", instr_valid); end
        n_checks++; if (instr !== 32'h101)  begin n_fail++; $display("FAIL stall_release_instr: got %h want 101", instr); end
    endtask

    task automatic test_priority();
        // load_start with a fetch in RUN drops the fetch.
        fetch_req  = 1'b1;
        fetch_addr = 16'd0;
        load_start = 1'b1;
        tick();
        idle();
        n_checks++; if (instr_valid !== 0) begin n_fail++; $display("FAIL prio_fetch_dropped: got %b want 0", instr_valid); end
        n_checks++; if (load_ready !== 1)  begin n_fail++; $display("FAIL prio_in_load: got %b want 1", load_ready); end
        // load_start with a last beat discards the beat.
        load_start = 1'b1;
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_data  = 32'hDEAD;
        tick();
        load_start = 1'b0;
        n_checks++; if (load_ready !== 1) begin n_fail++; $display("FAIL prio_beat_discarded: got %b want 1", load_ready); end
        load_data = 32'hBEEF;
        tick();
        idle();
        n_checks++; if (load_done !== 1) begin n_fail++; $display("FAIL prio_done: got %b want 1", load_done); end
        fetch_req  = 1'b1;
        fetch_addr = 16'd0;
        tick();
        n_checks++; if (instr !== 32'hBEEF) begin n_fail++; $display("FAIL prio_word0: got %h want beef", instr); end
        fetch_addr = 16'd1;
        tick();
        n_checks++; if (instr !== '0) begin n_fail++; $display("FAIL prio_word1: got %h want 0", instr); end
        idle();
    endtask

    task automatic test_reset_midload();
        int done_cnt = 0;
        idle();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data = 32'h1; tick(); if (load_done === 1'b1) done_cnt++;
        load_data = 32'h2; tick(); if (load_done === 1'b1) done_cnt++;
        idle();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (load_ready !== 0) begin n_fail++; $display("FAIL midload_reset_ready: got %b want 0", load_ready); end
        n_checks++; if (mem_ready !== 0)  begin n_fail++; $display("FAIL midload_reset_mem_ready: got %b want 0", mem_ready); end
        #1 rst_n = 1'b1;
        tick(); if (load_done === 1'b1) done_cnt++;
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL midload_no_done: got %0d pulses want 0", done_cnt); end
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_data  = 32'hAA;
        tick();
        idle();
        n_checks++; if (load_done !== 1) begin n_fail++; $display("FAIL reload_done: got %b want 1", load_done); end
        fetch_req  = 1'b1;
        fetch_addr = 16'd1;
        tick();
        n_checks++; if (instr !== '0)      begin n_fail++; $display("FAIL reload_word1: got %h want 0", instr); end
        n_checks++; if (instr_valid !== 1) begin n_fail++; $display("FAIL reload_word1_valid: got %b want 1", instr_valid); end
        fetch_addr = 16'd0;
        tick();
        n_checks++; if (instr !== 32'hAA) begin n_fail++; $display("FAIL reload_word0: got %h want aa", instr); end
        idle();
    endtask

    task automatic test_random();
        idle();
        load_start = 1'b1;
        tick();
        for (int c = 0; c < 800; c++) begin
            load_start  = ($urandom_range(0, 39) == 0);
            load_valid  = $urandom_range(0, 1);
            load_data   = $urandom;
            load_last   = ($urandom_range(0, 5) == 0);
            fetch_req   = ($urandom_range(0, 3) != 0);
            fetch_stall = ($urandom_range(0, 4) == 0);
            fetch_addr  = ADDR_W'($urandom_range(0, 19));
            tick();
            n_checks++; if (instr !== m_instr)     begin n_fail++; $display("FAIL rnd_instr c%0d: got %h want %h", c, instr, m_instr); end
            n_checks++; if (instr_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, instr_valid, m_valid); end
            n_checks++; if (fetch_fault !== m_fault) begin n_fail++; $display("FAIL rnd_fault c%0d: got %b want %b", c, fetch_fault, m_fault); end
            n_checks++; if (load_done !== m_done)  begin n_fail++; $display("FAIL rnd_done c%0d: got %b want %b", c, load_done, m_done); end
            n_checks++; if (load_ready !== (m_mode == 1)) begin n_fail++; $display("FAIL rnd_load_ready c%0d: got %b want %b", c, load_ready, (m_mode == 1)); end
            n_checks++; if (mem_ready !== (m_mode == 2))  begin n_fail++; $display("FAIL rnd_mem_ready c%0d: got %b want %b", c, mem_ready, (m_mode == 2)); end
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_short();
        test_load_full();
        test_fault();
        test_stall();
        test_priority();
        test_reset_midload();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
